fetch_ifid: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline buffer, directly upstream of the decode/execute datapath.
- Owns the program counter, drives the instruction memory read address, and captures the returned word together with PC+4 into the IF/ID register.
- Supports stall (hold), flush (bubble insertion) and taken-branch redirect, so the single-cycle datapath can be split into a pipeline.

---
 rtl/fetch_ifid.sv | 88 ++++++++
 tb/tb_fetch_ifid.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fetch_ifid.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, drives the instruction-memory address, and supports stall, flush and branch redirect.
module fetch_ifid #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc4_s;

    assign pc4_s = pc_q + 32'd4;

    // Next-state selection for PC and IF/ID; redirect outranks stall, stall outranks advance.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;

        if (branch_taken) begin
            pc_d = {branch_target[31:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc4_s;
        end

        // The word fetched on a redirect or flush edge is wrong-path and must not be captured.
        if (branch_taken || flush) begin
            inst_d  = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (stall) begin
            inst_d  = inst_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end else begin
            inst_d  = imem_data;
            pc4_d   = pc4_s;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_inst  = inst_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_ifid.sv
// Testbench for fetch_ifid: directed vector table followed by randomized traffic against a reference model.
module tb_fetch_ifid;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, flush, branch_taken;
    logic [31:0] branch_target, imem_addr, imem_data, pc;
    logic [31:0] if_id_inst, if_id_pc4, fetch_count;
    logic        if_id_valid;

    always #5 clk = ~clk;

    fetch_ifid #(.RESET_PC(RPC), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
        .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: imem_word = 32'h2008_0005;
            32'h0000_0004: imem_word = 32'h2009_0003;
            32'h0000_0008: imem_word = 32'h0109_5020;
            default:       imem_word = a ^ 32'h3C01_0000;
        endcase
    endfunction

    assign imem_data = imem_word(imem_addr);

    typedef struct {
        logic        r, s, f, b;
        logic [31:0] tgt;
        logic [31:0] e_pc, e_inst, e_pc4;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(input logic r, s, f, b, input logic [31:0] tgt,
                                input logic [31:0] e_pc, e_inst, e_pc4,
                                input logic e_valid, input logic [31:0] e_cnt);
        vec_t v;
        v.r = r; v.s = s; v.f = f; v.b = b; v.tgt = tgt;
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_pc4 = e_pc4;
        v.e_valid = e_valid; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, e_inst, e_pc4,
                             input logic e_valid, input logic [31:0] e_cnt);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".addr"}, imem_addr, e_pc);
        chk({tag, ".inst"}, if_id_inst, e_inst);
        chk({tag, ".pc4"}, if_id_pc4, e_pc4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
        chk({tag, ".count"}, fetch_count, e_cnt);
    endtask

    task automatic drive(input logic r, s, f, b, input logic [31:0] t);
        rst = r; stall = s; flush = f; branch_taken = b; branch_target = t;
        @(posedge clk);
        #1;
    endtask

    // reference model state
    logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
    logic        m_valid;

    task automatic model_edge(input logic r, s, f, b, input logic [31:0] t);
        logic [31:0] seq_pc;
        if (r) begin
            m_pc = RPC; m_inst = NOP; m_pc4 = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
        end else begin
            seq_pc = m_pc + 32'd4;
            if (b || f) begin
                m_inst = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
            end else if (!s) begin
                m_inst = imem_word(m_pc); m_pc4 = seq_pc; m_valid = 1'b1;
                m_cnt = m_cnt + 32'd1;
            end
            if (b) m_pc = t & 32'hFFFF_FFFC;
            else if (!s) m_pc = seq_pc;
        end
    endtask

    initial begin
        logic r, s, f, b;
        logic [31:0] t;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;

        // r s f b target        pc            inst                     pc4           v  cnt
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,  32'h0,        NOP,                     32'h0,        0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 32'h80, 32'h0,        NOP,                     32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h4,        32'h2008_0005,           32'h4,        1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h8,        32'h2009_0003,           32'h8,        1, 2));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h8,        32'h2009_0003,           32'h8,        1, 2));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h8,        32'h2009_0003,           32'h8,        1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'hC,        32'h0109_5020,           32'hC,        1, 3));
        tbl.push_back(mk(0, 0, 0, 1, 32'h42, 32'h40,       NOP,                     32'h0,        0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h44,       32'h3C01_0040,           32'h44,       1, 4));
        tbl.push_back(mk(0, 0, 0, 1, 32'h10, 32'h10,       NOP,                     32'h0,        0, 4));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0,  32'h10,       NOP,                     32'h0,        0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h14,       32'h3C01_0010,           32'h14,       1, 5));
        tbl.push_back(mk(0, 1, 0, 1, 32'h100, 32'h100,     NOP,                     32'h0,        0, 5));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,  32'h104,      NOP,                     32'h0,        0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h108,      32'h3C01_0104,           32'h108,      1, 6));
        tbl.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, NOP,             32'h0,        0, 6));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h0,        32'hC3FE_FFFC,           32'h0,        1, 7));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h4,        32'h2008_0005,           32'h4,        1, 8));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,  32'h4,        32'h2008_0005,           32'h4,        1, 8));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,  32'h0,        NOP,                     32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,  32'h4,        32'h2008_0005,           32'h4,        1, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].b, tbl[i].tgt);
            check_all($sformatf("dir%0d", i), tbl[i].e_pc, tbl[i].e_inst,
                      tbl[i].e_pc4, tbl[i].e_valid, tbl[i].e_cnt);
        end

        model_edge(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        check_all("rnd_rst", m_pc, m_inst, m_pc4, m_valid, m_cnt);

        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 7) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
            model_edge(r, s, f, b, t);
            drive(r, s, f, b, t);
            check_all($sformatf("rnd%0d", k), m_pc, m_inst, m_pc4, m_valid, m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
